// File: rtl/fact_pkg.sv
// fact_pkg: shared constants for the fact_unit factorial accelerator.
//   - Register word offsets (decoded from addr[3:2]).
//   - STATUS register bit positions.
//   - FSM state encoding.
//   - Default largest N whose factorial fits in a 32-bit result.
package fact_pkg;

  // Register word offsets
  localparam logic [1:0] OFF_N      = 2'd0;
  localparam logic [1:0] OFF_GO     = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_RESULT = 2'd3;

  // STATUS bit positions
  localparam int unsigned STAT_DONE = 0;
  localparam int unsigned STAT_ERR  = 1;
  localparam int unsigned STAT_BUSY = 2;
  localparam int unsigned STAT_IE   = 3;

  // 12! = 0x1C8CFC00 is the largest factorial that fits in 32 bits
  localparam int unsigned MAX_N_DEF = 12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fact_datapath.sv
// fact_datapath: accumulator, down-counter and multiplier for the
// iterative factorial.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load_i     : start a run (acc=1, cnt=n_i)
//   zero_i     : overflow abort (acc=0, cnt=0); wins over load_i
//   step_i     : one multiply step (acc*=cnt, cnt-=1)
//   n_i        : operand to load into the counter
//   acc_o      : running / final accumulator
//   cnt_le1_o  : counter has reached 0 or 1, run is finished
module fact_datapath #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned N_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               zero_i,
  input  logic               step_i,
  input  logic [N_WIDTH-1:0] n_i,
  output logic [WIDTH-1:0]   acc_o,
  output logic               cnt_le1_o
);

  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [N_WIDTH-1:0] cnt_q, cnt_d;

  // Next-state selection for accumulator and counter
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (zero_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (load_i) begin
      acc_d = WIDTH'(1);
      cnt_d = n_i;
    end else if (step_i) begin
      // Only the low WIDTH bits of the product are kept
      acc_d = acc_q * WIDTH'(cnt_q);
      cnt_d = cnt_q - N_WIDTH'(1);
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end
  end

  // Accumulator and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc_o     = acc_q;
  assign cnt_le1_o = (cnt_q <= N_WIDTH'(1));

endmodule

// File: rtl/fact_unit.sv
// fact_unit: memory-mapped iterative factorial accelerator.
// CPU writes N, writes GO, polls STATUS (or takes irq), reads RESULT.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   we       : write enable for this unit
//   addr     : access address, only addr[3:2] decoded
//   wdata    : write data
//   rdata    : combinational read data for addr[3:2]
//   irq      : done & ie, registered (tied 0 unless FACT_IRQ_EN)
// Optional feature macro: FACT_IRQ_EN (writable ie bit and irq output).
module fact_unit
  import fact_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned N_WIDTH = 4,
  parameter int unsigned MAX_N   = MAX_N_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [31:0]      addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             irq
);

  localparam logic [N_WIDTH-1:0] MAX_N_L = N_WIDTH'(MAX_N);

  state_e             state_q;
  logic [N_WIDTH-1:0] n_q;
  logic               done_q, err_q, ie_q, irq_q;

  logic [1:0]         off_s;
  logic               busy_s, go_wr_s, n_wr_s, go_acc_s, n_big_s;
  logic               load_s, zero_s, step_s, cnt_le1_s;
  logic [WIDTH-1:0]   acc_s;
  logic               unused_bits_s;

  assign off_s    = addr[3:2];
  assign busy_s   = (state_q == S_BUSY);
  // N and GO writes are dropped while a run is in progress
  assign n_wr_s   = we && (off_s == OFF_N) && !busy_s;
  assign go_wr_s  = we && (off_s == OFF_GO) && wdata[0];
  assign go_acc_s = go_wr_s && !busy_s;
  assign n_big_s  = (n_q > MAX_N_L);
  assign load_s   = go_acc_s && !n_big_s;
  assign zero_s   = go_acc_s && n_big_s;
  assign step_s   = busy_s && !cnt_le1_s;

  assign unused_bits_s = ^{addr[31:4], addr[1:0], wdata};

  fact_datapath #(
    .WIDTH   (WIDTH),
    .N_WIDTH (N_WIDTH)
  ) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load_s),
    .zero_i    (zero_s),
    .step_i    (step_s),
    .n_i       (n_q),
    .acc_o     (acc_s),
    .cnt_le1_o (cnt_le1_s)
  );

  // Control FSM, N register and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ie_q    <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (n_wr_s) begin
        n_q <= wdata[N_WIDTH-1:0];
      end
      case (state_q)
        S_IDLE, S_DONE: begin
          if (go_wr_s) begin
            if (n_big_s) begin
              // Overflowing N finishes immediately with an error
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_BUSY;
              done_q  <= 1'b0;
              err_q   <= 1'b0;
            end
          end
        end
        S_BUSY: begin
          if (cnt_le1_s) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
`ifdef FACT_IRQ_EN
      if (we && (off_s == OFF_STATUS)) begin
        ie_q <= wdata[STAT_IE];
      end
      // Registered from current flags, so irq trails done by one cycle
      irq_q <= done_q & ie_q;
`else
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
`endif
    end
  end

  assign irq = irq_q;

  // Read mux, same-cycle response
  always_comb begin
    rdata = '0;
    case (off_s)
      OFF_N: begin
        rdata[N_WIDTH-1:0] = n_q;
      end
      OFF_GO: begin
        rdata = '0;
      end
      OFF_STATUS: begin
        rdata[STAT_DONE] = done_q;
        rdata[STAT_ERR]  = err_q;
        rdata[STAT_BUSY] = busy_s;
        rdata[STAT_IE]   = ie_q;
      end
      OFF_RESULT: begin
        rdata = acc_s;
      end
      default: begin
        rdata = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_fact_unit.sv
// tb_fact_unit: self-checking bench for fact_unit with a result scoreboard.
module tb_fact_unit;
  import fact_pkg::*;

  logic        clk;
  logic        rst;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb_q[$];

  fact_unit #(
    .WIDTH   (32),
    .N_WIDTH (4),
    .MAX_N   (12)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fact_model(input int n);
    logic [31:0] r;
    r = 32'd1;
    if (n > 12) begin
      r = 32'd0;
    end else begin
      for (int i = 2; i <= n; i++) r = r * 32'(i);
    end
    return r;
  endfunction

  // Upper/lower address bits are randomised to show they are ignored
  function automatic logic [31:0] mk_addr(input logic [1:0] off);
    logic [31:0] r;
    r = $urandom();
    return {r[31:4], off, r[1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] d);
    we    = 1'b1;
    addr  = mk_addr(off);
    wdata = d;
    tick();
    we    = 1'b0;
    wdata = 32'd0;
  endtask

  task automatic rd(input logic [1:0] off, output logic [31:0] d);
    addr = mk_addr(off);
    #1;
    d = rdata;
  endtask

  task automatic sb_check_result();
    logic [31:0] d;
    check_val("sb_not_empty", 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      rd(OFF_RESULT, d);
      check_val("result", d, sb_q.pop_front());
    end
  endtask

  // Poll STATUS until done, counting cycles with busy set
  task automatic wait_done(output int busy_cnt);
    logic [31:0] d;
    bit seen;
    busy_cnt = 0;
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      rd(OFF_STATUS, d);
      if (d[STAT_DONE]) begin
        seen = 1'b1;
      end else begin
        if (d[STAT_BUSY]) busy_cnt++;
        tick();
      end
    end
    check_val("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic run_n(input int n);
    logic [31:0] d;
    int bc;
    int exp_busy;
    exp_busy = (n > 12) ? 0 : ((n == 0) ? 1 : n);
    wr(OFF_N, 32'(n));
    rd(OFF_N, d);
    check_val("n_readback", d, 32'(n));
    wr(OFF_GO, 32'd1);
    sb_q.push_back(fact_model(n));
    wait_done(bc);
    check_val("busy_cycles", 32'(bc), 32'(exp_busy));
    rd(OFF_STATUS, d);
    check_val("status", d & 32'h7, (n > 12) ? 32'h3 : 32'h1);
    sb_check_result();
  endtask

  initial begin
    logic [31:0] d;
    int bc;
    rst   = 1'b1;
    we    = 1'b0;
    addr  = 32'd0;
    wdata = 32'd0;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    for (int o = 0; o < 4; o++) begin
      rd(2'(o), d);
      check_val("reset_read", d, 32'd0);
    end
    check_val("reset_irq", 32'(irq), 32'd0);

    // Normal run and known constant
    run_n(5);
    rd(OFF_RESULT, d);
    check_val("fact5_const", d, 32'h0000_0078);

    // Boundaries
    run_n(0);
    run_n(1);
    run_n(12);
    rd(OFF_RESULT, d);
    check_val("fact12_const", d, 32'h1C8C_FC00);
    run_n(3);
    run_n(7);

    // Overflow: done+err on the cycle after GO, never busy
    run_n(13);
    run_n(15);

    // Writes to read-only RESULT ignored; GO reads 0
    wr(OFF_RESULT, 32'hDEAD_BEEF);
    rd(OFF_RESULT, d);
    check_val("ro_result", d, 32'd0);
    rd(OFF_GO, d);
    check_val("go_reads0", d, 32'd0);

    // Busy protection: writes to N and GO ignored mid-run
    wr(OFF_N, 32'd6);
    wr(OFF_GO, 32'd1);
    sb_q.push_back(fact_model(6));
    wr(OFF_N, 32'd3);
    wr(OFF_GO, 32'd1);
    rd(OFF_STATUS, d);
    check_val("still_busy", d & 32'h7, 32'h4);
    wait_done(bc);
    check_val("prot_busy_cycles", 32'(bc), 32'd4);
    sb_check_result();
    rd(OFF_RESULT, d);
    check_val("fact6_const", d, 32'h0000_02D0);
    rd(OFF_N, d);
    check_val("n_kept", d, 32'd6);

    // Reset in the middle of a run
    wr(OFF_N, 32'd7);
    wr(OFF_GO, 32'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int o = 0; o < 4; o++) begin
      rd(2'(o), d);
      check_val("midrun_reset_read", d, 32'd0);
    end
    check_val("midrun_reset_irq", 32'(irq), 32'd0);

`ifdef FACT_IRQ_EN
    wr(OFF_STATUS, 32'h8);
    rd(OFF_STATUS, d);
    check_val("ie_set", d, 32'h8);
    wr(OFF_N, 32'd4);
    wr(OFF_GO, 32'd1);
    sb_q.push_back(fact_model(4));
    wait_done(bc);
    check_val("irq_lags_done", 32'(irq), 32'd0);
    tick();
    check_val("irq_rise", 32'(irq), 32'd1);
    sb_check_result();
    rd(OFF_RESULT, d);
    check_val("fact4_const", d, 32'h0000_0018);
    wr(OFF_GO, 32'd1);
    sb_q.push_back(fact_model(4));
    tick();
    check_val("irq_clr_go", 32'(irq), 32'd0);
    wait_done(bc);
    tick();
    check_val("irq_rise2", 32'(irq), 32'd1);
    sb_check_result();
    wr(OFF_STATUS, 32'h0);
    tick();
    check_val("irq_clr_ie", 32'(irq), 32'd0);
`else
    wr(OFF_STATUS, 32'hF);
    rd(OFF_STATUS, d);
    check_val("ie_absent", d, 32'd0);
    run_n(4);
    tick();
    check_val("irq_tied0", 32'(irq), 32'd0);
`endif

    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
